// File: rtl/apb_dpmem_pkg.sv
// Shared types and helpers for the APB memory with a native read port.
package apb_dpmem_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_dpmem_mp_state_e;

  // An inverted window (lo > hi) means no read-only region at all.
  function automatic logic is_ro(input logic [63:0] addr,
                                 input logic [63:0] lo,
                                 input logic [63:0] hi);
    logic hit;
    if (lo > hi) begin
      hit = 1'b0;
    end else begin
      hit = (addr >= lo) && (addr <= hi);
    end
    return hit;
  endfunction

endpackage

// File: rtl/dpmem_ram.sv
// Word array with one byte-enable synchronous write port and two asynchronous
// read ports (APB side and local port B).
module dpmem_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned IDX_WIDTH  = 8,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic [IDX_WIDTH-1:0]  raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [IDX_WIDTH-1:0]  raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Byte-lane write; lanes with a clear strobe keep their old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < int'(STRB_WIDTH); i++) begin
        if (wstrb_i[i]) begin
          mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/apb_dpmem_mp.sv
// APB4 completer memory with per-direction wait states, a read-only window,
// SLVERR classification and a registered read-first native read port B.
module apb_dpmem_mp
  import apb_dpmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 3,
  parameter int unsigned RO_LO      = 0,
  parameter int unsigned RO_HI      = 15,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_err
);

  localparam int unsigned IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [WAIT_CNT_W-1:0] RD_CNT   = WAIT_CNT_W'(RD_WAIT);
  localparam logic [WAIT_CNT_W-1:0] WR_CNT   = WAIT_CNT_W'(WR_WAIT);
  localparam logic [WAIT_CNT_W-1:0] CNT_ZERO = {WAIT_CNT_W{1'b0}};
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);

  if (RD_WAIT > 15) begin : g_bad_rd_wait
    $error("apb_dpmem_mp: RD_WAIT must be in 0..15");
  end
  if (WR_WAIT > 15) begin : g_bad_wr_wait
    $error("apb_dpmem_mp: WR_WAIT must be in 0..15");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("apb_dpmem_mp: DATA_WIDTH must be a multiple of 8");
  end

  apb_dpmem_mp_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  b_err_q, b_err_d;

  logic                  setup_s, take_setup_s, wr_en_s, fwd_s;
  logic                  new_err_s;
  logic [WAIT_CNT_W-1:0] new_cnt_s;
  logic [IDX_WIDTH-1:0]  apb_ridx_s;
  logic [DATA_WIDTH-1:0] ram_a_s, ram_b_s, apb_rdata_s;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                        input logic [DATA_WIDTH-1:0] new_v,
                                                        input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(STRB_WIDTH); i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return res;
  endfunction

  assign setup_s      = PSEL && !PENABLE;
  assign take_setup_s = setup_s && ((state_q == IDLE) || ((state_q == ACCESS) && pready_q));
  assign wr_en_s      = (state_q == ACCESS) && pready_q && write_q && !err_q && !PRESET;
  assign new_err_s    = (PADDR >= DEPTH_A) ||
                        (PWRITE && is_ro(64'(PADDR), 64'(RO_LO), 64'(RO_HI)));
  assign new_cnt_s    = new_err_s ? CNT_ZERO : (PWRITE ? WR_CNT : RD_CNT);
  assign apb_ridx_s   = take_setup_s ? PADDR[IDX_WIDTH-1:0] : addr_q[IDX_WIDTH-1:0];

  // A zero-wait read set up on the edge that completes a write to the same
  // word must see the bytes being written, not the stale array contents.
  assign fwd_s        = wr_en_s && take_setup_s && (PADDR == addr_q);
  assign apb_rdata_s  = fwd_s ? merge_bytes(ram_a_s, PWDATA, PSTRB) : ram_a_s;

  dpmem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_ram (
    .clk_i     (PCLK),
    .we_i      (wr_en_s),
    .waddr_i   (addr_q[IDX_WIDTH-1:0]),
    .wdata_i   (PWDATA),
    .wstrb_i   (PSTRB),
    .raddr_a_i (apb_ridx_s),
    .rdata_a_o (ram_a_s),
    .raddr_b_i (b_addr[IDX_WIDTH-1:0]),
    .rdata_b_o (ram_b_s)
  );

  // Transfer sequencing: classify on setup, count wait states, drive the completion cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (take_setup_s) begin
      state_d = ACCESS;
      addr_d  = PADDR;
      write_d = PWRITE;
      err_d   = new_err_s;
      cnt_d   = new_cnt_s;
      if (new_cnt_s == CNT_ZERO) begin
        pready_d  = 1'b1;
        pslverr_d = new_err_s;
        prdata_d  = (new_err_s || PWRITE) ? '0 : apb_rdata_s;
      end else begin
        pready_d  = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ACCESS: begin
          if (pready_q) begin
            state_d = IDLE;
          end else if (!PSEL) begin
            state_d = DONE;
          end else if (cnt_q <= CNT_ONE) begin
            cnt_d     = CNT_ZERO;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (err_q || write_q) ? '0 : apb_rdata_s;
          end else begin
            cnt_d     = cnt_q - CNT_ONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Port B: the array is read before this edge's write lands, giving read-first data.
  always_comb begin
    b_rdata_d = b_rdata_q;
    b_err_d   = b_err_q;
    if (b_en) begin
      if (b_addr >= DEPTH_A) begin
        b_rdata_d = '0;
        b_err_d   = 1'b1;
      end else begin
        b_rdata_d = ram_b_s;
        b_err_d   = 1'b0;
      end
    end else begin
      b_rdata_d = b_rdata_q;
      b_err_d   = b_err_q;
    end
  end

  // Control state and registered outputs; the array itself is not reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= CNT_ZERO;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      b_rdata_q <= '0;
      b_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      b_rdata_q <= b_rdata_d;
      b_err_q   <= b_err_d;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;
  assign b_rdata = b_rdata_q;
  assign b_err   = b_err_q;

endmodule

// File: tb/tb_apb_dpmem_mp.sv
// Self-checking bench for apb_dpmem_mp: directed scenarios plus randomized
// APB / port-B traffic checked against a word-array reference model.
module tb_apb_dpmem_mp;
  import apb_dpmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int RDW   = 1;
  localparam int WRW   = 3;
  localparam int ROH   = 15;   // read-only window used here is 0..ROH

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  logic        b_en, b_err;
  logic [31:0] b_addr, b_rdata;

  always #5 PCLK = ~PCLK;

  apb_dpmem_mp #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (DEPTH),
    .RD_WAIT (RDW), .WR_WAIT (WRW), .RO_LO (0), .RO_HI (ROH)
  ) dut (
    .PCLK (PCLK), .PRESET (PRESET), .PSEL (PSEL), .PENABLE (PENABLE),
    .PWRITE (PWRITE), .PADDR (PADDR), .PWDATA (PWDATA), .PSTRB (PSTRB),
    .PREADY (PREADY), .PRDATA (PRDATA), .PSLVERR (PSLVERR),
    .b_en (b_en), .b_addr (b_addr), .b_rdata (b_rdata), .b_err (b_err)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic exp_err(input logic w, input logic [31:0] a);
    return (a >= 32'(DEPTH)) || (w && (a <= 32'(ROH)));
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // Compare port B against the model value taken before the sampling edge.
  task automatic b_compare(input string tag, input logic [31:0] ba,
                           input logic [31:0] exp_d, input bit exp_k);
    if (ba >= 32'(DEPTH)) begin
      check({tag, "_err"}, 64'(b_err), 64'd1);
      check({tag, "_data"}, 64'(b_rdata), 64'd0);
    end else begin
      check({tag, "_err"}, 64'(b_err), 64'd0);
      if (exp_k) check({tag, "_data"}, 64'(b_rdata), 64'(exp_d));
      else begin
        ref_mem[int'(ba)] = b_rdata;
        known[int'(ba)]   = 1'b1;
      end
    end
  endtask

  task automatic b_read(input string tag, input logic [31:0] a);
    logic [31:0] ed;
    bit          ek;
    ed = (a < 32'(DEPTH)) ? ref_mem[int'(a)] : 32'd0;
    ek = (a < 32'(DEPTH)) ? known[int'(a)] : 1'b1;
    b_en = 1'b1;
    b_addr = a;
    tick();
    b_en = 1'b0;
    b_compare(tag, a, ed, ek);
  endtask

  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit b_side, input logic [31:0] ba,
                          output logic [31:0] rd, output logic er, output int cyc);
    bit got;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s;
    tick();
    PENABLE = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      cyc++;
      if (PREADY === 1'b1) got = 1'b1;
      else tick();
    end
    if (!got) check("ready_timeout", 64'(PREADY), 64'd1);
    rd = PRDATA;
    er = PSLVERR;
    if (b_side) begin
      b_en = 1'b1;
      b_addr = ba;
    end
    tick();
    b_en = 1'b0;
  endtask

  task automatic do_apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit b2b, input bit b_side,
                        input logic [31:0] ba);
    logic [31:0] rd, bed;
    logic        er, e;
    bit          bek;
    int          cyc;
    e   = exp_err(w, a);
    bed = (ba < 32'(DEPTH)) ? ref_mem[int'(ba)] : 32'd0;
    bek = (ba < 32'(DEPTH)) ? known[int'(ba)] : 1'b1;
    apb_xfer(w, a, d, s, b_side, ba, rd, er, cyc);
    last_rd = rd;
    check(w ? "wr_cycles" : "rd_cycles", 64'(cyc), 64'(e ? 1 : (w ? WRW + 1 : RDW + 1)));
    check("pslverr", 64'(er), 64'(e));
    if (!w) begin
      if (e) check("rdata_on_err", 64'(rd), 64'd0);
      else if (known[int'(a)]) check("rdata", 64'(rd), 64'(ref_mem[int'(a)]));
      else begin
        ref_mem[int'(a)] = rd;
        known[int'(a)]   = 1'b1;
      end
    end
    check("ready_low_after", 64'(PREADY), 64'd0);
    if (b_side) b_compare("b_collide", ba, bed, bek);
    if (w && !e) ref_mem[int'(a)] = apply_strb(ref_mem[int'(a)], d, s);
    if (!b2b) begin
      PSEL = 1'b0;
      PENABLE = 1'b0;
    end
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; b_en = 1'b0; b_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 32'd0;
      known[i]   = 1'b0;
    end
    tick();
    tick();
    check("rst_pready", 64'(PREADY), 64'd0);
    check("rst_prdata", 64'(PRDATA), 64'd0);
    check("rst_pslverr", 64'(PSLVERR), 64'd0);
    check("rst_b_rdata", 64'(b_rdata), 64'd0);
    check("rst_b_err", 64'(b_err), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(IDLE));
    PRESET = 1'b0;
    tick();

    // Give every writable word a defined value.
    for (int a = ROH + 1; a < DEPTH; a++) do_apb(1'b1, 32'(a), 32'd0, 4'hF, 1'b1, 1'b0, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();

    do_apb(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'd0);
    tick();
    do_apb(1'b0, 32'h20, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);
    check("t1_read", 64'(last_rd), 64'h0000_0000_DEAD_BEEF);
    tick();
    do_apb(1'b1, 32'h20, 32'h11223344, 4'b0101, 1'b0, 1'b0, 32'd0);
    do_apb(1'b0, 32'h20, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);
    check("t2_merge", 64'(last_rd), 64'h0000_0000_DE22_BE44);

    b_read("t3_ro_pre", 32'h5);
    do_apb(1'b1, 32'h5, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 32'd0);
    do_apb(1'b0, 32'h5, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);
    b_read("t3_ro_post", 32'h5);
    do_apb(1'b0, 32'(DEPTH), 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);

    do_apb(1'b1, 32'h30, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, 32'd0);
    do_apb(1'b0, 32'h30, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);
    check("t4_b2b_read", 64'(last_rd), 64'h0000_0000_0BAD_F00D);

    do_apb(1'b1, 32'h40, 32'hCAFE0000, 4'hF, 1'b0, 1'b1, 32'h40);
    check("t5_read_first", 64'(b_rdata), 64'd0);
    b_read("t5_new", 32'h40);
    check("t5_new_data", 64'(b_rdata), 64'h0000_0000_CAFE_0000);
    b_read("t5_oor", 32'(DEPTH + 3));
    b_addr = 32'h40;
    tick();
    tick();
    check("b_hold_data", 64'(b_rdata), 64'd0);
    check("b_hold_err", 64'(b_err), 64'd1);

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h50;
    PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    tick();
    PENABLE = 1'b1;
    tick();
    PRESET = 1'b1;
    tick();
    check("t6_rst_pready", 64'(PREADY), 64'd0);
    check("t6_rst_state", 64'(dut.state_q), 64'(IDLE));
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    do_apb(1'b0, 32'h50, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h60;
    PWDATA = 32'h12345678; PSTRB = 4'hF;
    tick();
    PENABLE = 1'b1;
    PSEL = 1'b0;
    PENABLE = 1'b0;
    tick();
    check("t6_abort_done", 64'(dut.state_q), 64'(DONE));
    check("t6_abort_pready", 64'(PREADY), 64'd0);
    tick();
    check("t6_abort_idle", 64'(dut.state_q), 64'(IDLE));
    do_apb(1'b0, 32'h60, 32'd0, 4'h0, 1'b0, 1'b0, 32'd0);

    for (int n = 0; n < 250; n++) begin
      int          op;
      logic [31:0] a, d;
      logic [3:0]  s;
      bit          b2b;
      op  = int'($urandom_range(0, 3));
      a   = 32'($urandom_range(0, DEPTH + 8));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      b2b = 1'($urandom_range(0, 1));
      case (op)
        0:       do_apb(1'b1, a, d, s, b2b, 1'b0, 32'd0);
        1:       do_apb(1'b0, a, d, s, b2b, 1'b0, 32'd0);
        2:       b_read("rnd_b", a);
        default: do_apb(1'b1, a, d, s, b2b, 1'b1, a);
      endcase
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
